// File: rtl/jtdsp16_seq_pkg.sv
// Shared types and constants for the jtdsp16 program sequencer.
package jtdsp16_seq_pkg;

  // Widest address and loop count a loop entry can carry.
  // The sequencer's AW and CW parameters must not exceed these.
  localparam int SEQ_AW_MAX = 32;
  localparam int SEQ_CW_MAX = 32;

  // Interrupt line k vectors to VEC_BASE + k.
  localparam int VEC_BASE = 1;
  localparam int RESET_PC = 0;

  // One hardware do-loop: first body address, last body address
  // ('end' is a reserved word, so the field is called 'last'), and
  // the remaining iterations including the current one.
  typedef struct packed {
    logic [SEQ_AW_MAX-1:0] head;
    logic [SEQ_AW_MAX-1:0] last;
    logic [SEQ_CW_MAX-1:0] left;
  } loop_ent_t;

endpackage

// File: rtl/jtdsp16_lifo.sv
// Generic shift-register LIFO. Entry 0 is the top of the stack.
// A push onto a full stack shifts the oldest entry out of the bottom.
// A pop from an empty stack does nothing. 'load' rewrites the top entry
// in place. If several requests arrive together, push wins over pop,
// and pop wins over load.
module jtdsp16_lifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cen,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         load,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNTW = $clog2(DEPTH+1);

  logic [W-1:0] mem [DEPTH];

  assign top   = mem[0];
  assign full  = (count == CNTW'(DEPTH));
  assign empty = (count == '0);

  // Stack contents and occupancy; everything advances only on cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count <= '0;
    end else if (cen) begin
      if (push) begin
        for (int i = DEPTH-1; i > 0; i--) mem[i] <= mem[i-1];
        mem[0] <= din;
        if (!full) count <= count + 1'b1;
      end else if (pop) begin
        if (!empty) begin
          for (int i = 0; i < DEPTH-1; i++) mem[i] <= mem[i+1];
          mem[DEPTH-1] <= '0;
          count <= count - 1'b1;
        end
      end else if (load && !empty) begin
        mem[0] <= din;
      end
    end
  end

endmodule

// File: rtl/jtdsp16_pc_seq.sv
// jtdsp16 program sequencer. It owns PC, the return stack, the
// do-loop stack and the interrupt return register (pi).
// The next PC is chosen in this priority order:
//   interrupt entry > loop end > goto/call > ret > iret > halt > sequential/do.
module jtdsp16_pc_seq #(
  parameter int AW     = 16,
  parameter int RDEPTH = 4,
  parameter int LDEPTH = 3,
  parameter int LW     = 4,
  parameter int CW     = 7,
  parameter int NIRQ   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cen,
  input  logic                          halt,
  input  logic                          goto,
  input  logic                          call,
  input  logic                          ret,
  input  logic                          iret,
  input  logic [AW-1:0]                 target,
  input  logic                          do_start,
  input  logic [LW-1:0]                 do_len,
  input  logic [CW-1:0]                 do_cnt,
  input  logic [NIRQ-1:0]               irq,
  input  logic                          no_int,
  output logic [AW-1:0]                 pc,
  output logic [NIRQ-1:0]               iack,
  output logic                          in_irq,
  output logic [$clog2(LDEPTH+1)-1:0]   loop_depth,
  output logic [$clog2(RDEPTH+1)-1:0]   ret_depth,
  output logic [1:0]                    err
);

  import jtdsp16_seq_pkg::*;

  // Each loop-stack word is packed as {head, last, left}.
  localparam int LEW = 2*AW + CW;

  logic [AW-1:0]   pi;
  logic [AW-1:0]   pc_inc, pc_nxt, pi_nxt, len_eff, irq_vec;
  logic [NIRQ-1:0] iack_nxt;
  logic            in_irq_nxt;
  logic [1:0]      err_nxt;

  logic            rs_push, rs_pop, rs_full, rs_empty;
  logic [AW-1:0]   rs_top;

  logic            ls_push, ls_pop, ls_load, ls_full, ls_empty;
  logic [LEW-1:0]  ls_din, ls_top;

  loop_ent_t       cur_ent, new_ent;
  logic            branch, irq_take, loop_end;

  jtdsp16_lifo #(.DEPTH(RDEPTH), .W(AW)) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (rs_push),
    .pop   (rs_pop),
    .load  (1'b0),
    .din   (pc_inc),
    .top   (rs_top),
    .count (ret_depth),
    .full  (rs_full),
    .empty (rs_empty)
  );

  jtdsp16_lifo #(.DEPTH(LDEPTH), .W(LEW)) u_loop_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .push  (ls_push),
    .pop   (ls_pop),
    .load  (ls_load),
    .din   (ls_din),
    .top   (ls_top),
    .count (loop_depth),
    .full  (ls_full),
    .empty (ls_empty)
  );

  assign pc_inc  = pc + 1'b1;
  assign len_eff = (do_len == '0) ? AW'(1) : AW'(do_len);
  assign ls_din  = {AW'(new_ent.head), AW'(new_ent.last), CW'(new_ent.left)};

  // Unpack the top loop entry into the shared struct view.
  always_comb begin
    cur_ent      = '0;
    cur_ent.head = SEQ_AW_MAX'(ls_top[LEW-1 -: AW]);
    cur_ent.last = SEQ_AW_MAX'(ls_top[CW +: AW]);
    cur_ent.left = SEQ_CW_MAX'(ls_top[CW-1:0]);
  end

  // Vector address of the lowest-numbered (highest-priority) active request.
  always_comb begin
    irq_vec = AW'(VEC_BASE);
    for (int i = NIRQ-1; i >= 0; i--) begin
      if (irq[i]) irq_vec = AW'(VEC_BASE + i);
    end
  end

  // A do instruction also redirects flow, so it defers interrupt entry.
  // Interrupts are never taken with a loop active.
  assign branch   = goto | call | ret | iret | do_start;
  assign irq_take = (|irq) && !in_irq && !halt && !no_int && ls_empty && !branch;
  assign loop_end = !ls_empty && !halt && (cur_ent.last == SEQ_AW_MAX'(pc));

  // Next-state selection for PC, pi, interrupt status, errors and both stacks.
  always_comb begin
    pc_nxt     = pc;
    pi_nxt     = pi;
    in_irq_nxt = in_irq;
    iack_nxt   = '0;
    err_nxt    = err;
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
    ls_push    = 1'b0;
    ls_pop     = 1'b0;
    ls_load    = 1'b0;
    new_ent    = '0;
    if (irq_take) begin
      pc_nxt     = irq_vec;
      pi_nxt     = pc_inc;
      in_irq_nxt = 1'b1;
      iack_nxt   = irq & (~irq + 1'b1);
    end else if (loop_end) begin
      if (cur_ent.left > SEQ_CW_MAX'(1)) begin
        pc_nxt       = AW'(cur_ent.head);
        new_ent      = cur_ent;
        new_ent.left = cur_ent.left - SEQ_CW_MAX'(1);
        ls_load      = 1'b1;
      end else begin
        ls_pop = 1'b1;
        pc_nxt = pc_inc;
      end
    end else if (goto) begin
      pc_nxt = target;
    end else if (call) begin
      rs_push = 1'b1;
      pc_nxt  = target;
      if (rs_full) err_nxt[0] = 1'b1;
    end else if (ret) begin
      if (rs_empty) begin
        pc_nxt     = AW'(RESET_PC);
        err_nxt[0] = 1'b1;
      end else begin
        rs_pop = 1'b1;
        pc_nxt = rs_top;
      end
    end else if (iret) begin
      pc_nxt     = pi;
      in_irq_nxt = 1'b0;
    end else if (halt) begin
      pc_nxt = pc;
    end else if (do_start) begin
      if (do_cnt == '0) begin
        pc_nxt = pc + len_eff + AW'(1);
      end else if (ls_full) begin
        // The do is dropped; the body runs once as straight-line code.
        err_nxt[1] = 1'b1;
        pc_nxt     = pc_inc;
      end else begin
        ls_push      = 1'b1;
        new_ent.head = SEQ_AW_MAX'(pc_inc);
        new_ent.last = SEQ_AW_MAX'(pc + len_eff);
        new_ent.left = SEQ_CW_MAX'(do_cnt);
        pc_nxt       = pc_inc;
      end
    end else begin
      pc_nxt = pc_inc;
    end
  end

  // Architectural registers; iack is a registered one-cycle pulse that
  // holds along with everything else while cen is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= AW'(RESET_PC);
      pi     <= '0;
      in_irq <= 1'b0;
      iack   <= '0;
      err    <= '0;
    end else if (cen) begin
      pc     <= pc_nxt;
      pi     <= pi_nxt;
      in_irq <= in_irq_nxt;
      iack   <= iack_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_jtdsp16_pc_seq.sv
// Directed, table-driven bench for jtdsp16_pc_seq with default parameters.
module tb_jtdsp16_pc_seq;

  localparam int OP_NONE = 0;
  localparam int OP_GOTO = 1;
  localparam int OP_CALL = 2;
  localparam int OP_RET  = 3;
  localparam int OP_IRET = 4;
  localparam int OP_HALT = 5;
  localparam int OP_DO   = 6;

  // Clock/reset and DUT signals
  logic        clk = 1'b0;
  logic        rst_n, cen, halt, goto, call, ret, iret, do_start, no_int;
  logic [15:0] target;
  logic [3:0]  do_len;
  logic [6:0]  do_cnt;
  logic [3:0]  irq;
  logic [15:0] pc;
  logic [3:0]  iack;
  logic        in_irq;
  logic [1:0]  loop_depth;
  logic [2:0]  ret_depth;
  logic [1:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          op;
    logic [15:0] tgt;
    logic [3:0]  len;
    logic [6:0]  cnt;
    logic [3:0]  irq;
    logic        nint;
    logic [15:0] epc;
    logic [3:0]  eiack;
    logic        ein;
    logic [1:0]  eld;
    logic [2:0]  erd;
    logic [1:0]  eerr;
  } vec_t;

  vec_t vecs[$];

  jtdsp16_pc_seq #(
    .AW(16), .RDEPTH(4), .LDEPTH(3), .LW(4), .CW(7), .NIRQ(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .halt       (halt),
    .goto       (goto),
    .call       (call),
    .ret        (ret),
    .iret       (iret),
    .target     (target),
    .do_start   (do_start),
    .do_len     (do_len),
    .do_cnt     (do_cnt),
    .irq        (irq),
    .no_int     (no_int),
    .pc         (pc),
    .iack       (iack),
    .in_irq     (in_irq),
    .loop_depth (loop_depth),
    .ret_depth  (ret_depth),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int op, input logic [15:0] tgt,
                        input logic [3:0] len, input logic [6:0] cnt);
    goto     = (op == OP_GOTO);
    call     = (op == OP_CALL);
    ret      = (op == OP_RET);
    iret     = (op == OP_IRET);
    halt     = (op == OP_HALT);
    do_start = (op == OP_DO);
    target   = tgt;
    do_len   = len;
    do_cnt   = cnt;
  endtask

  // Scoreboard
  task automatic check(input string what, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h, want 0x%0h", what, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [15:0] epc, input logic [3:0] eiack,
                           input logic ein, input logic [1:0] eld, input logic [2:0] erd,
                           input logic [1:0] eerr);
    check("pc",         idx, 32'(pc),         32'(epc));
    check("iack",       idx, 32'(iack),       32'(eiack));
    check("in_irq",     idx, 32'(in_irq),     32'(ein));
    check("loop_depth", idx, 32'(loop_depth), 32'(eld));
    check("ret_depth",  idx, 32'(ret_depth),  32'(erd));
    check("err",        idx, 32'(err),        32'(eerr));
  endtask

  task automatic r(input int op, input int tgt, input int len, input int cnt,
                   input int irq_v, input int nint, input int epc, input int eiack,
                   input int ein, input int eld, input int erd, input int eerr);
    vec_t v;
    v.op    = op;
    v.tgt   = 16'(tgt);
    v.len   = 4'(len);
    v.cnt   = 7'(cnt);
    v.irq   = 4'(irq_v);
    v.nint  = 1'(nint);
    v.epc   = 16'(epc);
    v.eiack = 4'(eiack);
    v.ein   = 1'(ein);
    v.eld   = 2'(eld);
    v.erd   = 3'(erd);
    v.eerr  = 2'(eerr);
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cen   = 1'b0;
    irq   = '0;
    no_int = 1'b0;
    set_op(OP_NONE, 16'h0, 4'h0, 7'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Vector table: op, target, len, cnt, irq, no_int -> pc, iack, in_irq, loop_depth, ret_depth, err
    // Plain sequencing, call/ret
    for (int i = 1; i <= 5; i++) r(OP_NONE, 0, 0, 0, 0, 0, i, 0, 0, 0, 0, 0);
    r(OP_GOTO, 'h3,  0, 0, 0, 0, 'h3,  0, 0, 0, 0, 0);
    r(OP_CALL, 'h40, 0, 0, 0, 0, 'h40, 0, 0, 0, 1, 0);
    r(OP_RET,  0,    0, 0, 0, 0, 'h4,  0, 0, 0, 0, 0);
    // Single loop, len 2 cnt 3
    r(OP_GOTO, 'h10, 0, 0, 0, 0, 'h10, 0, 0, 0, 0, 0);
    r(OP_DO,   0,    2, 3, 0, 0, 'h11, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h11, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h11, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h13, 0, 0, 0, 0, 0);
    // cnt 0 skips the body
    r(OP_GOTO, 'h10, 0, 0, 0, 0, 'h10, 0, 0, 0, 0, 0);
    r(OP_DO,   0,    2, 0, 0, 0, 'h13, 0, 0, 0, 0, 0);
    // Nested loops: outer 0x10 len4 cnt2, inner 0x11 len1 cnt3
    r(OP_GOTO, 'h10, 0, 0, 0, 0, 'h10, 0, 0, 0, 0, 0);
    r(OP_DO,   0,    4, 2, 0, 0, 'h11, 0, 0, 1, 0, 0);
    r(OP_DO,   0,    1, 3, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h13, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h14, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h11, 0, 0, 1, 0, 0);
    r(OP_DO,   0,    1, 3, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h12, 0, 0, 2, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h13, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h14, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h15, 0, 0, 0, 0, 0);
    // Interrupts: deferred by branch, taken, no nesting, iret
    r(OP_GOTO, 'h7, 0, 0, 'b0110, 0, 'h7, 0,      0, 0, 0, 0);
    r(OP_NONE, 0,   0, 0, 'b0110, 0, 'h2, 'b0010, 1, 0, 0, 0);
    r(OP_NONE, 0,   0, 0, 'b0110, 0, 'h3, 0,      1, 0, 0, 0);
    r(OP_IRET, 0,   0, 0, 0,      0, 'h8, 0,      0, 0, 0, 0);
    // no_int defers, then line 0 taken
    r(OP_GOTO, 'h7, 0, 0, 0,      0, 'h7, 0,      0, 0, 0, 0);
    r(OP_NONE, 0,   0, 0, 'b0110, 1, 'h8, 0,      0, 0, 0, 0);
    r(OP_NONE, 0,   0, 0, 'b0001, 0, 'h1, 'b0001, 1, 0, 0, 0);
    r(OP_IRET, 0,   0, 0, 0,      0, 'h9, 0,      0, 0, 0, 0);
    // Active loop defers entry until the loop pops
    r(OP_GOTO, 'h20, 0, 0, 0,      0, 'h20, 0,      0, 0, 0, 0);
    r(OP_DO,   0,    1, 2, 0,      0, 'h21, 0,      0, 1, 0, 0);
    r(OP_NONE, 0,    0, 0, 'b0100, 0, 'h21, 0,      0, 1, 0, 0);
    r(OP_NONE, 0,    0, 0, 'b0100, 0, 'h22, 0,      0, 0, 0, 0);
    r(OP_NONE, 0,    0, 0, 'b0100, 0, 'h3,  'b0100, 1, 0, 0, 0);
    r(OP_IRET, 0,    0, 0, 0,      0, 'h23, 0,      0, 0, 0, 0);
    // halt blocks entry
    r(OP_HALT, 0, 0, 0, 'b0001, 0, 'h23, 0, 0, 0, 0, 0);
    r(OP_NONE, 0, 0, 0, 0,      0, 'h24, 0, 0, 0, 0, 0);
    // do_len 0 behaves as 1
    r(OP_DO,   0, 0, 0, 0, 0, 'h26, 0, 0, 0, 0, 0);
    r(OP_DO,   0, 0, 2, 0, 0, 'h27, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h27, 0, 0, 1, 0, 0);
    r(OP_NONE, 0, 0, 0, 0, 0, 'h28, 0, 0, 0, 0, 0);
    // Address wrap
    r(OP_GOTO, 'hFFFF, 0, 0, 0, 0, 'hFFFF, 0, 0, 0, 0, 0);
    r(OP_NONE, 0,      0, 0, 0, 0, 'h0,    0, 0, 0, 0, 0);
    // Return stack overflow (drop oldest) and underflow
    r(OP_GOTO, 'h50, 0, 0, 0, 0, 'h50, 0, 0, 0, 0, 0);
    r(OP_CALL, 'h60, 0, 0, 0, 0, 'h60, 0, 0, 0, 1, 0);
    r(OP_CALL, 'h70, 0, 0, 0, 0, 'h70, 0, 0, 0, 2, 0);
    r(OP_CALL, 'h80, 0, 0, 0, 0, 'h80, 0, 0, 0, 3, 0);
    r(OP_CALL, 'h90, 0, 0, 0, 0, 'h90, 0, 0, 0, 4, 0);
    r(OP_CALL, 'hA0, 0, 0, 0, 0, 'hA0, 0, 0, 0, 4, 1);
    r(OP_RET,  0,    0, 0, 0, 0, 'h91, 0, 0, 0, 3, 1);
    r(OP_RET,  0,    0, 0, 0, 0, 'h81, 0, 0, 0, 2, 1);
    r(OP_RET,  0,    0, 0, 0, 0, 'h71, 0, 0, 0, 1, 1);
    r(OP_RET,  0,    0, 0, 0, 0, 'h61, 0, 0, 0, 0, 1);
    r(OP_RET,  0,    0, 0, 0, 0, 'h0,  0, 0, 0, 0, 1);
    // Loop stack overflow: fourth do is ignored
    r(OP_GOTO, 'h30, 0, 0, 0, 0, 'h30, 0, 0, 0, 0, 1);
    r(OP_DO,   0,    8, 2, 0, 0, 'h31, 0, 0, 1, 0, 1);
    r(OP_DO,   0,    6, 2, 0, 0, 'h32, 0, 0, 2, 0, 1);
    r(OP_DO,   0,    4, 2, 0, 0, 'h33, 0, 0, 3, 0, 1);
    r(OP_DO,   0,    1, 2, 0, 0, 'h34, 0, 0, 3, 0, 3);
    r(OP_NONE, 0,    0, 0, 0, 0, 'h35, 0, 0, 3, 0, 3);

    // Reset state
    do_reset();
    check_all(0, 16'h0, 4'h0, 1'b0, 2'd0, 3'd0, 2'd0);
    rst_n = 1'b1;
    cen   = 1'b1;

    // Apply the table
    foreach (vecs[i]) begin
      set_op(vecs[i].op, vecs[i].tgt, vecs[i].len, vecs[i].cnt);
      irq    = vecs[i].irq;
      no_int = vecs[i].nint;
      tick();
      check_all(i + 1, vecs[i].epc, vecs[i].eiack, vecs[i].ein,
                vecs[i].eld, vecs[i].erd, vecs[i].eerr);
    end

    // Halt at a loop end with cen toggling
    do_reset();
    rst_n = 1'b1;
    cen   = 1'b1;
    set_op(OP_GOTO, 16'h10, 4'h0, 7'h0); tick();
    set_op(OP_DO, 16'h0, 4'h1, 7'h2);    tick();
    check_all(200, 16'h11, 4'h0, 1'b0, 2'd1, 3'd0, 2'd0);
    set_op(OP_HALT, 16'h0, 4'h0, 7'h0);
    for (int i = 0; i < 3; i++) begin
      cen = (i != 1);
      tick();
      check_all(201 + i, 16'h11, 4'h0, 1'b0, 2'd1, 3'd0, 2'd0);
    end
    cen = 1'b1;
    set_op(OP_NONE, 16'h0, 4'h0, 7'h0);
    tick();
    check_all(204, 16'h11, 4'h0, 1'b0, 2'd1, 3'd0, 2'd0);
    tick();
    check_all(205, 16'h12, 4'h0, 1'b0, 2'd0, 3'd0, 2'd0);

    // iack and pc hold while cen is low
    irq = 4'b0001;
    tick();
    check_all(206, 16'h1, 4'b0001, 1'b1, 2'd0, 3'd0, 2'd0);
    irq = 4'b0000;
    cen = 1'b0;
    tick();
    check_all(207, 16'h1, 4'b0001, 1'b1, 2'd0, 3'd0, 2'd0);
    tick();
    check_all(208, 16'h1, 4'b0001, 1'b1, 2'd0, 3'd0, 2'd0);
    cen = 1'b1;
    tick();
    check_all(209, 16'h2, 4'b0000, 1'b1, 2'd0, 3'd0, 2'd0);

    // Asynchronous reset mid-loop and mid-interrupt
    set_op(OP_GOTO, 16'h10, 4'h0, 7'h0); tick();
    set_op(OP_DO, 16'h0, 4'h2, 7'h3);    tick();
    check_all(210, 16'h11, 4'h0, 1'b1, 2'd1, 3'd0, 2'd0);
    set_op(OP_NONE, 16'h0, 4'h0, 7'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check_all(211, 16'h0, 4'h0, 1'b0, 2'd0, 3'd0, 2'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all(212, 16'h1, 4'h0, 1'b0, 2'd0, 3'd0, 2'd0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
